// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the I-cache/memory.
// The fetch stage drives the request and address; memory returns the hit and the data.
interface fetch_stage_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;

    modport master (output imemREN, imemaddr, input ihit, imemload);
    modport slave  (input imemREN, imemaddr, output ihit, imemload);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC, requests instructions and fills the IF/ID register.
// Priority each edge in RUN is halt > redirect > stall > ihit > miss; HALTED is absorbing until reset.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               nRST,
    fetch_stage_if.master      imem,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_addr,
    input  logic               halt,
    output logic [31:0]        instr_if_id,
    output logic [31:0]        NPC_if_id,
    output logic               valid_if_id,
    output logic [31:0]        fetch_count
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state_q;
    logic        ren_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] npc_q;
    logic        valid_q;
    logic [31:0] count_q;

    logic [31:0] pc_plus4_s;
    logic [31:0] redir_aligned_s;

    // Sequential add wraps naturally at 2^32; targets are forced word-aligned.
    assign pc_plus4_s      = pc_q + 32'd4;
    assign redir_aligned_s = redirect_addr & 32'hFFFF_FFFC;

    // Fetch FSM with its PC, IF/ID and counter state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            ren_q   <= 1'b1;
            pc_q    <= PC_INIT;
            instr_q <= 32'h0000_0000;
            npc_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
            count_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt) begin
                        state_q <= HALTED;
                        ren_q   <= 1'b0;
                        instr_q <= 32'h0000_0000;
                        npc_q   <= 32'h0000_0000;
                        valid_q <= 1'b0;
                    end else if (redirect) begin
                        pc_q    <= redir_aligned_s;
                        instr_q <= 32'h0000_0000;
                        npc_q   <= 32'h0000_0000;
                        valid_q <= 1'b0;
                    end else if (stall) begin
                        pc_q    <= pc_q;
                    end else if (imem.ihit) begin
                        pc_q    <= pc_plus4_s;
                        instr_q <= imem.imemload;
                        npc_q   <= pc_plus4_s;
                        valid_q <= 1'b1;
                        count_q <= count_q + 32'd1;
                    end else begin
                        instr_q <= 32'h0000_0000;
                        npc_q   <= 32'h0000_0000;
                        valid_q <= 1'b0;
                    end
                end
                HALTED: begin
                    ren_q <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: recover to a quiet RUN state.
                    state_q <= RUN;
                    ren_q   <= 1'b1;
                    instr_q <= 32'h0000_0000;
                    npc_q   <= 32'h0000_0000;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imemREN  = ren_q;
    assign imem.imemaddr = pc_q;
    assign instr_if_id   = instr_q;
    assign NPC_if_id     = npc_q;
    assign valid_if_id   = valid_q;
    assign fetch_count   = count_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: PC_INIT, 32'h00000000, PC value loaded on reset.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 nRST  input  1  asynchronous, active-low reset.
REQ-004 ihit  input  1  instruction memory returns valid imemload this cycle.
REQ-005 imemload  input  32  instruction word for imemaddr.
REQ-006 stall  input  1  hazard unit hold; IF/ID and PC frozen.
REQ-007 redirect  input  1  taken branch/jump/jr resolved downstream; flush and re-steer.
REQ-008 redirect_addr  input  32  target PC for redirect.
REQ-009 halt  input  1  halt instruction retired; stop fetching.
REQ-010 imemREN  output  1  instruction read request.
REQ-011 imemaddr  output  32  current PC.
REQ-012 instr_if_id  output  32  registered instruction to decode.
REQ-013 NPC_if_id  output  32  registered PC+4 of that instruction.
REQ-014 valid_if_id  output  1  IF/ID holds a real instruction; 0 means bubble.
REQ-015 fetch_count  output  32  number of instructions accepted into IF/ID.

Function
REQ-016 Two states, RUN and HALTED; reset enters RUN.
REQ-017 imemREN SHALL be 1 in RUN and 0 in HALTED.
REQ-018 imemaddr SHALL equal the PC register combinationally.
REQ-019 Per-edge priority in RUN SHALL be halt > redirect > stall > ihit > miss.
REQ-020 halt: next state HALTED, IF/ID cleared (instr 0, NPC 0, valid 0), PC held.
REQ-021 redirect: PC <= {redirect_addr[31:2],2'b00}, IF/ID cleared; any ihit data that cycle is discarded and fetch_count is not incremented.
REQ-022 stall (no halt/redirect): PC, IF/ID, and fetch_count held, regardless of ihit.
REQ-023 ihit (no halt/redirect/stall): PC <= PC+4, instr_if_id <= imemload, NPC_if_id <= PC+4, valid_if_id <= 1, fetch_count += 1.
REQ-024 Miss (ihit=0, no halt/redirect/stall): PC held, IF/ID loaded with bubble (instr 0, NPC 0, valid 0).
REQ-025 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000); fetch_count SHALL wrap the same way.
REQ-026 HALTED is absorbing: all inputs ignored, PC/IF/ID/fetch_count held until reset.
REQ-027 Fetch latency: an instruction returned with ihit at edge N SHALL be visible on instr_if_id after edge N.

Reset
REQ-028 nRST low SHALL immediately force state RUN, PC = PC_INIT, instr_if_id = 0, NPC_if_id = 0, valid_if_id = 0, fetch_count = 0, independent of CLK.
REQ-029 Reset asserted mid-miss, mid-stall, or in HALTED SHALL behave identically to power-on reset; first request after release uses imemaddr = PC_INIT.

Verification
REQ-030 Reset release, ihit=1 for 3 cycles with imemload A,B,C -> imemaddr 0,4,8; IF/ID shows A/NPC 4, B/8, C/12; fetch_count 3.
REQ-031 ihit=0 for 2 cycles at PC 0x10 -> PC holds 0x10, valid_if_id 0, instr 0; next ihit advances to 0x14.
REQ-032 stall=1 with ihit=1 at PC 0x20 holding instr X -> PC 0x20, IF/ID X unchanged, fetch_count unchanged.
REQ-033 redirect=1, redirect_addr 0x103, ihit=1 same cycle -> PC 0x100, valid_if_id 0, fetch_count unchanged; redirect+stall together -> redirect wins.
REQ-034 halt=1 together with redirect -> HALTED, imemREN 0, PC unchanged; further ihit/redirect ignored; nRST pulse -> RUN, PC = PC_INIT.
REQ-035 PC_INIT 32'hFFFFFFFC, one ihit -> NPC_if_id 0, PC 0.
